serial_add_sequencer: RTL
=========================

// Module: serial_add_sequencer
//
// PURPOSE
//  Sequences a bit-serial full adder to perform WIDTH-bit parallel additions.
//  Accepts operand pairs via valid/ready and shifts them LSB-first through an
//  internal 1-bit full adder, one bit per clock. The adder and its carry are
//  built from ^ | & ~ only. Returns the assembled sum and carry-out via
//  valid/ready. Sits between a parallel producer/consumer and the serial adder.
//
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..64
//
// PORTS
//  clk        in   1      clock; all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand pair present
//  in_ready   out  1      block can accept operands
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      initial carry-in
//  out_valid  out  1      result present
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  (A + B + cin) mod 2^WIDTH
//  out_cout   out  1      final carry-out
//  busy       out  1      high in RUN or DONE
//
// BEHAVIOUR
//  Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0,
//   busy=0, internal carry=0, bit counter=0.
//  FSM states and transitions:
//   IDLE: in_ready=1. On in_valid&in_ready: latch in_a/in_b into shift
//    registers, carry<=in_cin, counter<=0, go to RUN.
//   RUN: in_ready=0. Each cycle:
//    - s = a_sh[0]^b_sh[0]^carry.
//    - carry <= (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0])).
//    - Result register shifts right with s inserted at MSB.
//    - a_sh/b_sh shift right; counter increments.
//    - On the WIDTH-th RUN edge go to DONE; out_sum=result, out_cout=carry.
//   DONE: out_valid=1. Hold out_sum/out_cout stable while out_ready=0.
//    On out_valid&out_ready: go to IDLE and drop out_valid.
//  Latency: out_valid rises on the WIDTH-th clock edge after the accept edge.
//   Minimum issue interval is WIDTH+2 cycles. No overlap; in_ready is high
//   only in IDLE.
//  in_valid while in_ready=0: ignored; operands are not sampled.
//  out_ready while out_valid=0: ignored.
//  out_sum/out_cout are undefined-free. They retain the last result after
//   the DONE handshake until the next op completes; they are zero after reset.
//  Counter width: $clog2(WIDTH+1). Compare exactly against WIDTH, with no
//   wrap-around reliance.
//  Reset mid-operation (RUN or DONE) aborts the op:
//   - The op is discarded and no out_valid is produced for it.
//   - All reset values apply on the next cycle.
//  Carry arithmetic: full WIDTH+1 result; out_cout is bit WIDTH of A+B+cin.
//  The + operator is not used in the datapath. The counter may use it.
//
// TESTING (WIDTH=8)
//  - 0x5A + 0x3C, cin=0 -> out_sum=0x96, out_cout=0.
//    out_valid exactly 8 edges after accept.
//  - 0xFF + 0x01, cin=0 -> out_sum=0x00, out_cout=1.
//    0xFF + 0xFF, cin=1 -> out_sum=0xFF, out_cout=1.
//  - Backpressure: result 0x96 with out_ready=0 for 5 cycles ->
//    out_valid and out_sum held stable. in_ready=0 throughout.
//    IDLE is entered only after out_ready=1.
//  - in_valid held high with new operands during RUN ->
//    no effect on the current result (0x96). Second op accepted only in IDLE.
//  - rst asserted on RUN cycle 3 -> next cycle in_ready=1, out_valid=0,
//    out_sum=0. Subsequent 0x01+0x01 yields 0x02.
//  - 1000 random back-to-back ops with random out_ready ->
//    every {out_cout,out_sum} matches the reference A+B+cin.

Source files
------------

// File: rtl/serial_add_sequencer.sv
// Feeds WIDTH-bit operand pairs LSB-first through a 1-bit full adder and returns the parallel sum and carry-out.
// Latency: out_valid rises WIDTH edges after the accept edge; the minimum issue interval is WIDTH+2 cycles.
// Backpressure: in_ready is high only in IDLE. The result is held stable in DONE until out_ready is seen.
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  // The A shift register also collects the result.
  // Each sum bit enters at the MSB as the operand bit it replaces leaves at the LSB.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_nxt;
  logic [CW-1:0]    cnt_nxt;

  // Single-bit full adder on the current LSBs, plus the next bit count.
  always_comb begin
    s_bit   = a_sh[0] ^ b_sh[0] ^ carry;
    c_nxt   = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    cnt_nxt = cnt + CW'(1);
  end

  // Control FSM and serial datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= in_cin;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh  <= {s_bit, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= c_nxt;
          cnt   <= cnt_nxt;
          if (cnt_nxt == CW'(WIDTH)) begin
            out_sum  <= {s_bit, a_sh[WIDTH-1:1]};
            out_cout <= c_nxt;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake and status outputs are decoded directly from the state.
  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

endmodule
